// File: rtl/hc4e_pkg.sv
// hc4e_pkg: shared definitions for the HC4e ALU issue path.
//   DATA_W_DEF : default datapath width (must match the alu instance)
//   ALU_*      : alu sel_in codes the controller treats specially
//   state_t    : issue controller FSM encoding
package hc4e_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command/response handshake between the HC4e decoder
// (master) and the ALU issue controller (slave).
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/rd/rs        : alu sel code, destination (also in_B source), in_A source
//   cmd_imm_en/cmd_imm  : immediate replaces R[rs] as in_A
//   cmd_use_c           : feed the carry flag into carry_in
//   rsp_valid/rsp_ready : response handshake
//   rsp_data/rsp_carry  : value written to R[rd], carry flag after the operation
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs;
  logic              cmd_imm_en;
  logic [DATA_W-1:0] cmd_imm;
  logic              cmd_use_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm_en, cmd_imm, cmd_use_c, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm_en, cmd_imm, cmd_use_c, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one command at a time to an external combinational alu.
// Operands come from an internal register file; the result is written back to
// R[rd] and returned on the response channel together with the carry flag.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   bus (slave)      : command/response handshake
//   alu_in_A/in_B    : registered operands to the alu
//   alu_sel          : registered alu sel_in
//   alu_carry_in     : registered alu carry_in
//   alu_out          : alu result
//   alu_carry_out    : alu carry out
module alu_issue_ctrl
  import hc4e_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREG   = 4,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_in_A,
  output logic [DATA_W-1:0] alu_in_B,
  output logic [2:0]        alu_sel,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry_out
);

  state_t state_reg;
  state_t state_next;

  logic [DATA_W-1:0] regs_reg [NREG];
  logic              flag_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [2:0]        sel_reg;
  logic              cin_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_carry_reg;

  logic cmd_ready;
  logic rsp_valid;
  logic accept;
  logic exec;

  assign accept = bus.cmd_valid & cmd_ready;
  assign exec   = (state_reg == ST_EXEC);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.cmd_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ALU-drive registers are loaded only on accept, so the alu sees stable
  // operands for the whole EXEC cycle and keeps them afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sel_reg       <= '0;
      cin_reg       <= 1'b0;
      rd_reg        <= '0;
      flag_reg      <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_carry_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= bus.cmd_imm_en ? bus.cmd_imm : regs_reg[bus.cmd_rs];
        b_reg   <= regs_reg[bus.cmd_rd];
        sel_reg <= bus.cmd_op;
        cin_reg <= bus.cmd_use_c & flag_reg;
        rd_reg  <= bus.cmd_rd;
      end
      if (exec) begin
        rsp_data_reg <= alu_out;
        // Only ADD updates the carry flag; other ops report the preserved flag.
        if (sel_reg == ALU_ADD) begin
          flag_reg      <= alu_carry_out;
          rsp_carry_reg <= alu_carry_out;
        end else begin
          rsp_carry_reg <= flag_reg;
        end
      end
    end
  end

  // Register file: operands were captured at accept, so rd==rs write-back
  // never disturbs the values the alu is using.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   regs_reg[gi] <= '0;
      else if (exec && (rd_reg == REG_AW'(gi)))  regs_reg[gi] <= alu_out;
    end
  end

  assign alu_in_A      = a_reg;
  assign alu_in_B      = b_reg;
  assign alu_sel       = sel_reg;
  assign alu_carry_in  = cin_reg;

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_carry = rsp_carry_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench for alu_issue_ctrl with a
// behavioural HC4e alu (ADD with carry, XOR, PASS A) on the alu_* ports.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] alu_in_A;
  logic [3:0] alu_in_B;
  logic [2:0] alu_sel;
  logic       alu_carry_in;
  logic [3:0] alu_out;
  logic       alu_carry_out;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q [$];   // {data, carry}

  alu_issue_ctrl_if #(.DATA_W(4), .REG_AW(2)) bus ();

  alu_issue_ctrl #(.DATA_W(4), .NREG(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .alu_in_A      (alu_in_A),
    .alu_in_B      (alu_in_B),
    .alu_sel       (alu_sel),
    .alu_carry_in  (alu_carry_in),
    .alu_out       (alu_out),
    .alu_carry_out (alu_carry_out)
  );

  // Behavioural alu
  always_comb begin
    alu_out       = alu_in_A;
    alu_carry_out = 1'b0;
    case (alu_sel)
      3'b010:  {alu_carry_out, alu_out} = {1'b0, alu_in_A} + {1'b0, alu_in_B} + {4'b0, alu_carry_in};
      3'b100:  alu_out = alu_in_A ^ alu_in_B;
      default: alu_out = alu_in_A;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected response per completed handshake.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=%h required=none", bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          $display("rsp data=%h carry=%b (expected %h/%b)", bus.rsp_data, bus.rsp_carry, e[4:1], e[0]);
          check("rsp_data", 32'(bus.rsp_data), 32'(e[4:1]));
          check("rsp_carry", 32'(bus.rsp_carry), 32'(e[0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 with the command in EXEC.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic imm_en, input logic [3:0] imm, input logic use_c);
    int n;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_rd     = rd;
    bus.cmd_rs     = rs;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.cmd_use_c  = use_c;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=cmd_ready_low required=cmd_ready_high");
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_cmd_ready", 32'(bus.cmd_ready), 32'd0);
  endtask

  task automatic complete();
    int n;
    @(posedge clk); #1;
    check("latency_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=cmd_ready_low required=cmd_ready_high");
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic imm_en, input logic [3:0] imm, input logic use_c,
                        input logic [3:0] ed, input logic ec);
    exp_q.push_back({ed, ec});
    issue(op, rd, rs, imm_en, imm, use_c);
    complete();
  endtask

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 3'b000;
    bus.cmd_rd     = 2'd0;
    bus.cmd_rs     = 2'd0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = 4'h0;
    bus.cmd_use_c  = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst_alu_sel",   32'(alu_sel),       32'd0);
    check("rst_alu_in_A",  32'(alu_in_A),      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Load immediates
    do_cmd(3'b111, 2'd1, 2'd0, 1'b1, 4'h5, 1'b0, 4'h5, 1'b0);
    do_cmd(3'b111, 2'd2, 2'd0, 1'b1, 4'h3, 1'b0, 4'h3, 1'b0);
    // Carry preset: R3=F, then 1 + F -> 0, carry 1
    do_cmd(3'b111, 2'd3, 2'd0, 1'b1, 4'hF, 1'b0, 4'hF, 1'b0);
    do_cmd(3'b010, 2'd3, 2'd0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
    // ADC: 5 + 3 + 1 = 9, carry 0; inspect alu drive during EXEC
    exp_q.push_back({4'h9, 1'b0});
    issue(3'b010, 2'd2, 2'd1, 1'b0, 4'h0, 1'b1);
    check("adc_alu_in_A", 32'(alu_in_A), 32'h5);
    check("adc_alu_in_B", 32'(alu_in_B), 32'h3);
    check("adc_alu_sel", 32'(alu_sel), 32'h2);
    check("adc_alu_carry_in", 32'(alu_carry_in), 32'h1);
    complete();
    // Read back R2 and R1
    do_cmd(3'b111, 2'd0, 2'd2, 1'b0, 4'h0, 1'b0, 4'h9, 1'b0);
    do_cmd(3'b111, 2'd0, 2'd1, 1'b0, 4'h0, 1'b0, 4'h5, 1'b0);
    // XOR with carry flag set: flag must be preserved
    do_cmd(3'b111, 2'd3, 2'd0, 1'b1, 4'hF, 1'b0, 4'hF, 1'b0);
    do_cmd(3'b010, 2'd3, 2'd0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
    do_cmd(3'b111, 2'd1, 2'd0, 1'b1, 4'hC, 1'b0, 4'hC, 1'b1);
    do_cmd(3'b111, 2'd2, 2'd0, 1'b1, 4'hA, 1'b0, 4'hA, 1'b1);
    do_cmd(3'b100, 2'd2, 2'd1, 1'b0, 4'h0, 1'b0, 4'h6, 1'b1);
    // rd == rs: R2 = 6 + 6 = C
    do_cmd(3'b010, 2'd2, 2'd2, 1'b0, 4'h0, 1'b0, 4'hC, 1'b0);
    do_cmd(3'b111, 2'd0, 2'd2, 1'b0, 4'h0, 1'b0, 4'hC, 1'b0);

    // Backpressure: response held for 4 cycles, new command ignored
    bus.rsp_ready = 1'b0;
    exp_q.push_back({4'h7, 1'b0});
    issue(3'b111, 2'd1, 2'd0, 1'b1, 4'h7, 1'b0);
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 3'b111;
    bus.cmd_rd     = 2'd0;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 4'hF;
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_data",  32'(bus.rsp_data),  32'h7);
      check("bp_rsp_carry", 32'(bus.rsp_carry), 32'd0);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    // R0 must still hold C (ignored command did not write F)
    do_cmd(3'b111, 2'd0, 2'd0, 1'b0, 4'h0, 1'b0, 4'hC, 1'b0);

    // Reset during EXEC
    issue(3'b111, 2'd1, 2'd0, 1'b1, 4'h3, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("mid_rst_alu_in_A",  32'(alu_in_A),      32'd0);
    check("mid_rst_alu_sel",   32'(alu_sel),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_cmd(3'b111, 2'd0, 2'd1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    do_cmd(3'b111, 2'd0, 2'd2, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
